// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of the fetch-request, response, loader and byte-memory signals of
// imem_fetch_ctrl. The slave modport is the controller's view; the master
// modport is the surrounding system (IF stage, consumer, loader, memory).
interface imem_fetch_ctrl_if #(
  parameter int ADDR_W = 12
);
  // Fetch request from the IF stage
  logic              req_valid;
  logic [31:0]       req_addr;
  logic              req_ready;
  // Instruction response
  logic              rsp_valid;
  logic [31:0]       rsp_instr;
  logic              rsp_err;
  logic              rsp_ready;
  // Pipeline redirect
  logic              flush;
  // Program-loader byte writes
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;
  logic              ld_ready;
  // Byte-wide instruction memory port
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  req_valid, req_addr, rsp_ready, flush,
    input  ld_valid, ld_addr, ld_data, mem_rdata,
    output req_ready, rsp_valid, rsp_instr, rsp_err,
    output ld_ready, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_addr, rsp_ready, flush,
    output ld_valid, ld_addr, ld_data, mem_rdata,
    input  req_ready, rsp_valid, rsp_instr, rsp_err,
    input  ld_ready, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller for a byte-wide instruction memory.
// A 32-bit big-endian word is assembled from four sequential byte reads
// (addresses wrap inside the window); requests outside the window are
// answered at once with an error. A program loader can write bytes while
// the controller is idle and wins any same-cycle conflict with a fetch.
// Optional feature: define IMEM_FETCH_PERF_EN to build a completed-fetch
// counter on perf_fetch_cnt; otherwise the port is tied to zero.
module imem_fetch_ctrl #(
  parameter logic [31:0] IMEM_BASE = 32'hBFC00000,
  parameter int          ADDR_W    = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  imem_fetch_ctrl_if.slave    bus,
  output logic [31:0]         perf_fetch_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] base;
  logic [31:0]       instr;
  logic              err;
  logic              in_window;
  logic              req_fire;

  assign in_window     = (bus.req_addr[31:ADDR_W] == IMEM_BASE[31:ADDR_W]);
  assign bus.rsp_instr = instr;
  assign bus.rsp_err   = err;

  // State register; reset returns to IDLE without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and all handshake / memory-port outputs
  always_comb begin
    state_nxt     = state;
    req_fire      = 1'b0;
    bus.req_ready = 1'b0;
    bus.ld_ready  = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      IDLE: begin
        bus.ld_ready  = 1'b1;
        bus.req_ready = !bus.ld_valid && !bus.flush;
        // Loader write is gated by rst_n so reset silences the write strobe
        if (bus.ld_valid && rst_n) begin
          bus.mem_we    = 1'b1;
          bus.mem_addr  = bus.ld_addr;
          bus.mem_wdata = bus.ld_data;
        end else if (bus.req_valid && bus.req_ready) begin
          req_fire  = 1'b1;
          state_nxt = in_window ? FETCH : RESP;
        end
      end
      FETCH: begin
        // Addresses issued for cnt 0..3; cnt 4 only collects the last byte
        if (cnt <= 3'd3) bus.mem_addr = base + ADDR_W'(cnt);
        if (bus.flush)        state_nxt = IDLE;
        else if (cnt >= 3'd4) state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.flush)          state_nxt = IDLE;
        else if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fetch datapath: window offset, byte counter and assembled response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      base  <= '0;
      instr <= '0;
      err   <= 1'b0;
    end else if (req_fire) begin
      cnt   <= '0;
      instr <= '0;
      if (in_window) begin
        base <= bus.req_addr[ADDR_W-1:0];
        err  <= 1'b0;
      end else begin
        err  <= 1'b1;
      end
    end else if (state == FETCH) begin
      if (bus.flush || cnt >= 3'd4) cnt <= '0;
      else                          cnt <= cnt + 3'd1;
      // Read data lags the address by one cycle, so byte cnt-1 lands now
      if (!bus.flush) begin
        case (cnt)
          3'd1:    instr[31:24] <= bus.mem_rdata;
          3'd2:    instr[23:16] <= bus.mem_rdata;
          3'd3:    instr[15:8]  <= bus.mem_rdata;
          3'd4:    instr[7:0]   <= bus.mem_rdata;
          default: ;
        endcase
      end
    end
  end

`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] perf_q;

  // Count responses accepted by the consumer that carried a valid word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (bus.rsp_valid && bus.rsp_ready && !bus.flush && !err) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_q;
`else
  assign perf_fetch_cnt = '0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a byte-wide memory model that
// returns read data one cycle after the address.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] perf;
  logic [7:0]  mem [0:4095];
  logic [11:0] seen_addr [0:31];
  int          checks;
  int          errors;
  int          exp_perf;

  imem_fetch_ctrl_if #(.ADDR_W(12)) bus ();

  imem_fetch_ctrl #(
    .IMEM_BASE(32'hBFC00000),
    .ADDR_W   (12)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .perf_fetch_cnt(perf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous write, registered read
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] perf_exp();
`ifdef IMEM_FETCH_PERF_EN
    return exp_perf;
`else
    return 32'd0;
`endif
  endfunction

  // Loader byte write; starts and ends on a falling edge
  task automatic ld_byte(input logic [11:0] a, input logic [7:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = a;
    bus.ld_data  = d;
    #1;
    check_val("ld_we", {31'd0, bus.mem_we}, 32'd1);
    check_val("ld_addr", {20'd0, bus.mem_addr}, {20'd0, a});
    @(negedge clk);
    bus.ld_valid = 1'b0;
  endtask

  // Present a request at a falling edge and hold it through the accepting edge
  task automatic accept(input logic [31:0] a);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    #1;
    check_val("req_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Count falling edges after the accepting edge until rsp_valid; 0 = timeout
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      seen_addr[i] = bus.mem_addr;
      if (bus.rsp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] ei, input logic ee, input int el);
    int lat;
    wait_rsp(lat);
    check_val({tag, "_lat"}, lat, el);
    check_val({tag, "_instr"}, bus.rsp_instr, ei);
    check_val({tag, "_err"}, {31'd0, bus.rsp_err}, {31'd0, ee});
    @(negedge clk);
    check_val({tag, "_hold_vld"}, {31'd0, bus.rsp_valid}, 32'd1);
    check_val({tag, "_hold_instr"}, bus.rsp_instr, ei);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    if (!ee) exp_perf++;
    @(negedge clk);
    check_val({tag, "_vld_drop"}, {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          seen;
    logic [31:0] perf_before;
    checks        = 0;
    errors        = 0;
    exp_perf      = 0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b0;
    bus.flush     = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_data   = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check_val("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check_val("rst_mem_addr", {20'd0, bus.mem_addr}, 32'd0);
    check_val("rst_instr", bus.rsp_instr, 32'd0);
    check_val("rst_perf", perf, 32'd0);
    rst_n = 1'b1;

    // Basic in-window fetch
    ld_byte(12'h000, 8'h00);
    ld_byte(12'h001, 8'h00);
    ld_byte(12'h002, 8'h00);
    ld_byte(12'h003, 8'h93);
    accept(32'hBFC00000);
    check_rsp("fetch0", 32'h00000093, 1'b0, 6);

    // Fetch wrapping past the top of the window
    ld_byte(12'hFFE, 8'hAA);
    ld_byte(12'hFFF, 8'hBB);
    ld_byte(12'h000, 8'hCC);
    ld_byte(12'h001, 8'hDD);
    accept(32'hBFC00FFE);
    check_rsp("wrap", 32'hAABBCCDD, 1'b0, 6);
    check_val("wrap_a0", {20'd0, seen_addr[1]}, 32'h0FFE);
    check_val("wrap_a1", {20'd0, seen_addr[2]}, 32'h0FFF);
    check_val("wrap_a2", {20'd0, seen_addr[3]}, 32'h0000);
    check_val("wrap_a3", {20'd0, seen_addr[4]}, 32'h0001);

    // Out-of-window request
    perf_before = perf;
    accept(32'h00001000);
    check_rsp("oow", 32'h00000000, 1'b1, 1);
    check_val("oow_mem_addr", {20'd0, seen_addr[1]}, 32'd0);
    check_val("oow_perf", perf, perf_before);

    // Loader and request in the same cycle: loader wins
    bus.ld_valid  = 1'b1;
    bus.ld_addr   = 12'h010;
    bus.ld_data   = 8'h5A;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'hBFC00010;
    #1;
    check_val("confl_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check_val("confl_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
    check_val("confl_we", {31'd0, bus.mem_we}, 32'd1);
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
    #1;
    check_val("confl_req_ready2", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check_rsp("confl", 32'h5A000000, 1'b0, 6);
    check_val("perf3", perf, perf_exp());

    // Flush at cnt=2
    accept(32'hBFC00000);
    repeat (3) @(negedge clk);
    check_val("flush_pre_addr", {20'd0, bus.mem_addr}, 32'd2);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    #1;
    check_val("flush_idle_ready", {31'd0, bus.req_ready}, 32'd1);
    check_val("flush_idle_addr", {20'd0, bus.mem_addr}, 32'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check_val("flush_no_rsp", seen, 32'd0);

    // Asynchronous reset in the middle of a fetch
    accept(32'hBFC00FFE);
    repeat (4) @(negedge clk);
    check_val("mid_addr", {20'd0, bus.mem_addr}, 32'h0001);
    check_val("mid_instr", bus.rsp_instr, 32'hAABB0000);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_mem_addr", {20'd0, bus.mem_addr}, 32'd0);
    check_val("arst_instr", bus.rsp_instr, 32'd0);
    check_val("arst_err", {31'd0, bus.rsp_err}, 32'd0);
    check_val("arst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check_val("arst_we", {31'd0, bus.mem_we}, 32'd0);
    check_val("arst_perf", perf, 32'd0);
    exp_perf = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Accepted at the first rising edge after reset release
    accept(32'hBFC00000);
    check_rsp("post_rst", 32'hCCDD0093, 1'b0, 6);
    check_val("post_rst_perf", perf, perf_exp());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
